// File: rtl/adc_sampling_scheduler_pkg.sv
// rtl/adc_sampling_scheduler_pkg.sv - shared widths, sensor codes and default intervals
package adc_sampling_scheduler_pkg;

   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_DATA_W     = 14;
   localparam int DEF_NUM_SENS   = 4;
   localparam int DEF_SENS_W     = 2;
   localparam int DEF_CH_W       = 1;
   localparam int DEF_INTERVAL_W = 36;
   localparam int DEF_FIFO_AW    = 3;

   typedef enum logic [DEF_SENS_W-1:0] {
      SENS_TEMP  = 2'b00,
      SENS_HUMID = 2'b01,
      SENS_LIGHT = 2'b10,
      SENS_SOIL  = 2'b11
   } sensor_type_e;

   // Power-on programming suggestions at a 10 MHz clock.
   localparam logic [DEF_INTERVAL_W-1:0] DEF_INTERVAL_TEMP  = 36'd600_000_000;
   localparam logic [DEF_INTERVAL_W-1:0] DEF_INTERVAL_HUMID = 36'd600_000_000;
   localparam logic [DEF_INTERVAL_W-1:0] DEF_INTERVAL_LIGHT = 36'd10_000_000;
   localparam logic [DEF_INTERVAL_W-1:0] DEF_INTERVAL_SOIL  = 36'd48_000_000_000;

endpackage

// File: rtl/acker_sync_fifo.sv
// rtl/acker_sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty flags
module acker_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit tells full from empty when the address bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_sampling_scheduler.sv
// rtl/adc_sampling_scheduler.sv - per-slot interval sampling of ADC channels into a tagged FIFO
module adc_sampling_scheduler
   import adc_sampling_scheduler_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_SENS   = DEF_NUM_SENS,
   parameter int SENS_W     = DEF_SENS_W,
   parameter int CH_W       = DEF_CH_W,
   parameter int INTERVAL_W = DEF_INTERVAL_W,
   parameter int FIFO_AW    = DEF_FIFO_AW
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     adc_Data_out_valid,
   input  logic [NUM_CH*DATA_W-1:0] adc_Data_out,
   input  logic                     cfg_write,
   input  logic [SENS_W-1:0]        cfg_sensor,
   input  logic [CH_W-1:0]          cfg_channel,
   input  logic [INTERVAL_W-1:0]    cfg_interval,
   input  logic                     cfg_enable,
   input  logic                     da_Ready_for_Data_in,
   output logic [DATA_W-1:0]        da_Data_in,
   output logic                     da_Data_in_valid,
   output logic [SENS_W-1:0]        da_sensor_type,
   output logic                     overflow,
   input  logic                     overflow_clear
);

   logic [NUM_CH*DATA_W-1:0] sample_reg;
   logic                     sample_ok;

   logic [CH_W-1:0]       slot_channel  [NUM_SENS];
   logic [INTERVAL_W-1:0] slot_interval [NUM_SENS];
   logic [INTERVAL_W-1:0] slot_count    [NUM_SENS];
   logic [NUM_SENS-1:0]   slot_enable;
   logic [NUM_SENS-1:0]   pending;
   logic [NUM_SENS-1:0]   cfg_hit;
   logic [NUM_SENS-1:0]   running;
   logic [NUM_SENS-1:0]   fire;
   logic [NUM_SENS-1:0]   grant;
   logic [NUM_SENS-1:0]   lost;

   logic                     push_req;
   logic                     push_en;
   logic [SENS_W-1:0]        push_id;
   logic [DATA_W-1:0]        push_sample;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [SENS_W+DATA_W-1:0] head;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sample_reg <= '0;
         sample_ok  <= 1'b0;
      end else if (adc_Data_out_valid) begin
         sample_reg <= adc_Data_out;
         sample_ok  <= 1'b1;
      end
   end

   // A configuration write to a slot masks that slot's fire in the same cycle.
   for (genvar i = 0; i < NUM_SENS; i++) begin : g_slot
      assign cfg_hit[i] = cfg_write && (cfg_sensor == SENS_W'(i));
      assign running[i] = slot_enable[i] && (slot_interval[i] != '0);
      assign fire[i]    = running[i] && (slot_count[i] == INTERVAL_W'(1)) && !cfg_hit[i];
   end

   always_comb begin
      push_req = 1'b0;
      push_id  = '0;
      for (int i = NUM_SENS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            push_req = 1'b1;
            push_id  = SENS_W'(i);
         end
      end
   end

   assign push_en     = push_req && sample_ok && !fifo_full;
   assign grant       = push_en ? (NUM_SENS'(1) << push_id) : '0;
   assign push_sample = sample_reg[int'(slot_channel[push_id]) * DATA_W +: DATA_W];
   // A slot drained this cycle may refire without losing anything.
   assign lost        = fire & pending & ~grant;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SENS; i++) begin
            slot_channel[i]  <= '0;
            slot_interval[i] <= '0;
            slot_count[i]    <= '0;
         end
         slot_enable <= '0;
         pending     <= '0;
         overflow    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SENS; i++) begin
            if (cfg_hit[i]) begin
               slot_channel[i]  <= cfg_channel;
               slot_interval[i] <= cfg_interval;
               slot_enable[i]   <= cfg_enable;
               slot_count[i]    <= cfg_interval;
               pending[i]       <= 1'b0;
            end else begin
               if (running[i]) begin
                  slot_count[i] <= (slot_count[i] <= INTERVAL_W'(1)) ? slot_interval[i]
                                                                    : slot_count[i] - INTERVAL_W'(1);
               end
               if (fire[i])       pending[i] <= 1'b1;
               else if (grant[i]) pending[i] <= 1'b0;
            end
         end
         if (|lost)               overflow <= 1'b1;
         else if (overflow_clear) overflow <= 1'b0;
      end
   end

   acker_sync_fifo #(
      .WIDTH (SENS_W + DATA_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk       (clock),
      .rst_n     (reset),
      .push      (push_en),
      .push_data ({push_id, push_sample}),
      .pop       (da_Data_in_valid && da_Ready_for_Data_in),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign da_Data_in_valid = !fifo_empty;
   assign da_sensor_type   = head[SENS_W+DATA_W-1:DATA_W];
   assign da_Data_in       = head[DATA_W-1:0];

endmodule

// File: tb/tb_adc_sampling_scheduler.sv
// tb/tb_adc_sampling_scheduler.sv - directed and random checks against a slot/queue reference model
module tb_adc_sampling_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        adc_Data_out_valid = 1'b0;
   logic [27:0] adc_Data_out = '0;
   logic        cfg_write = 1'b0;
   logic [1:0]  cfg_sensor = '0;
   logic [0:0]  cfg_channel = '0;
   logic [35:0] cfg_interval = '0;
   logic        cfg_enable = 1'b0;
   logic        da_Ready_for_Data_in = 1'b0;
   logic [13:0] da_Data_in;
   logic        da_Data_in_valid;
   logic [1:0]  da_sensor_type;
   logic        overflow;
   logic        overflow_clear = 1'b0;

   adc_sampling_scheduler dut (
      .clock                (clock),
      .reset                (reset),
      .adc_Data_out_valid   (adc_Data_out_valid),
      .adc_Data_out         (adc_Data_out),
      .cfg_write            (cfg_write),
      .cfg_sensor           (cfg_sensor),
      .cfg_channel          (cfg_channel),
      .cfg_interval         (cfg_interval),
      .cfg_enable           (cfg_enable),
      .da_Ready_for_Data_in (da_Ready_for_Data_in),
      .da_Data_in           (da_Data_in),
      .da_Data_in_valid     (da_Data_in_valid),
      .da_sensor_type       (da_sensor_type),
      .overflow             (overflow),
      .overflow_clear       (overflow_clear)
   );

   always #5 clock = ~clock;

   int     vectors = 0;
   int     miscompares = 0;
   longint cyc = 0;

   // Slot fires land on edges load+N, load+2N, ...; pending bits and the FIFO are plain flags/queue.
   int          m_int  [4];
   bit          m_en   [4];
   int          m_ch   [4];
   longint      m_load [4];
   bit          m_pend [4];
   logic [15:0] q [$];
   bit          m_ovf;
   bit          m_ok;
   logic [27:0] m_sample;

   int ready_mode = 1;
   bit adc_count_mode = 1'b0;
   bit rnd_cfg = 1'b0;
   int seen_id [4];
   int id_log [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_int[i] = 0; m_en[i] = 0; m_ch[i] = 0; m_load[i] = 0; m_pend[i] = 0;
      end
      q.delete();
      m_ovf = 0;
      m_ok = 0;
      m_sample = '0;
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 4; i++) seen_id[i] = 0;
      id_log.delete();
   endtask

   task automatic model_edge();
      int          k = -1;
      int          idx;
      bit          hit;
      bit          fire;
      bit          lost_any = 0;
      logic [15:0] ent = '0;
      if (m_ok && q.size() < 8)
         for (int i = 3; i >= 0; i--) if (m_pend[i]) k = i;
      if (k >= 0) ent = {2'(k), m_sample[m_ch[k]*14 +: 14]};
      if (q.size() != 0 && da_Ready_for_Data_in) void'(q.pop_front());
      if (k >= 0) q.push_back(ent);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         hit  = cfg_write && (cfg_sensor == 2'(i));
         fire = !hit && m_en[i] && m_int[i] != 0 && cyc > m_load[i]
                && ((cyc - m_load[i]) % m_int[i]) == 0;
         if (hit) m_pend[i] = 0;
         else if (fire) begin
            if (m_pend[i] && k != i) lost_any = 1;
            m_pend[i] = 1;
         end else if (k == i) m_pend[i] = 0;
      end
      if (lost_any) m_ovf = 1;
      else if (overflow_clear) m_ovf = 0;
      if (adc_Data_out_valid) begin
         m_sample = adc_Data_out;
         m_ok = 1;
      end
      if (cfg_write) begin
         idx = int'(cfg_sensor);
         m_ch[idx]   = int'(cfg_channel);
         m_int[idx]  = int'(cfg_interval);
         m_en[idx]   = cfg_enable;
         m_load[idx] = cyc;
      end
   endtask

   task automatic tick();
      if (da_Data_in_valid && da_Ready_for_Data_in) begin
         seen_id[da_sensor_type]++;
         id_log.push_back(int'(da_sensor_type));
      end
      model_edge();
      @(posedge clock);
      #1;
      chk("valid", 32'(da_Data_in_valid), 32'(q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) begin
         chk("data", 32'(da_Data_in), 32'(q[0][13:0]));
         chk("sensor", 32'(da_sensor_type), 32'(q[0][15:14]));
      end
   endtask

   task automatic drive();
      if (adc_count_mode) begin
         adc_Data_out_valid = 1'b1;
         adc_Data_out = {14'(cyc), 14'($urandom)};
      end else begin
         adc_Data_out_valid = ($urandom % 3) != 0;
         adc_Data_out = 28'($urandom);
      end
      case (ready_mode)
         0:       da_Ready_for_Data_in = 1'b0;
         1:       da_Ready_for_Data_in = 1'b1;
         2:       da_Ready_for_Data_in = 1'($urandom);
         default: da_Ready_for_Data_in = ((cyc / 10) % 2) == 0;
      endcase
      if (rnd_cfg && ($urandom % 12) == 0) begin
         cfg_write    = 1'b1;
         cfg_sensor   = 2'($urandom);
         cfg_channel  = 1'($urandom);
         cfg_interval = 36'($urandom_range(0, 12));
         cfg_enable   = ($urandom % 4) != 0;
      end
      if (rnd_cfg && ($urandom % 25) == 0) overflow_clear = 1'b1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         drive();
         tick();
         cfg_write = 1'b0;
         overflow_clear = 1'b0;
      end
   endtask

   task automatic cfg(input int s, input int ch, input int iv, input int en);
      cfg_write    = 1'b1;
      cfg_sensor   = 2'(s);
      cfg_channel  = 1'(ch);
      cfg_interval = 36'(iv);
      cfg_enable   = 1'(en);
      run(1);
   endtask

   initial begin
      int  n;
      bit  found;
      model_reset();
      clear_seen();
      reset = 1'b0;
      #1;
      chk("rst_valid", 32'(da_Data_in_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_data", 32'(da_Data_in), 0);
      chk("rst_sensor", 32'(da_sensor_type), 0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;

      // Slot 0 on channel 1, interval 4, ADC counter on channel 1.
      ready_mode = 1;
      adc_count_mode = 1'b1;
      run(3);
      cfg(0, 1, 4, 1);
      n = 0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         run(1);
         n++;
         found = da_Data_in_valid;
      end
      chk("first_latency", 32'(n), 5);
      clear_seen();
      run(40);
      chk("words_in_40", 32'(seen_id[0]), 10);

      // All four slots at interval 8, written in id order.
      adc_count_mode = 1'b0;
      for (int i = 0; i < 4; i++) cfg(i, int'($urandom % 2), 8, 1);
      clear_seen();
      run(11);
      chk("order_len", 32'(id_log.size()), 4);
      for (int i = 0; i < 4; i++)
         if (id_log.size() > i) chk("order_id", 32'(id_log[i]), 32'(i));
      chk("order_no_ovf", 32'(overflow), 0);

      // Fill the FIFO with slot 1 at interval 1 while the sink stalls.
      for (int i = 0; i < 4; i++) cfg(i, 0, 0, 0);
      run(5);
      ready_mode = 0;
      cfg(1, int'($urandom % 2), 1, 1);
      run(9);
      chk("full_valid", 32'(da_Data_in_valid), 1);
      chk("ovf_before_loss", 32'(overflow), 0);
      run(1);
      chk("ovf_after_loss", 32'(overflow), 1);
      cfg(1, 0, 1, 0);
      overflow_clear = 1'b1;
      run(1);
      chk("ovf_cleared", 32'(overflow), 0);
      ready_mode = 1;
      clear_seen();
      run(12);
      chk("drained_words", 32'(seen_id[1]), 8);

      // Reconfigure slot 2 exactly on its fire edge.
      cfg(2, 0, 5, 1);
      run(4);
      cfg(2, 0, 0, 1);
      clear_seen();
      run(30);
      chk("silent_int0", 32'(seen_id[2]), 0);
      cfg(2, 1, 5, 1);
      run(4);
      cfg(2, 1, 5, 0);
      clear_seen();
      run(30);
      chk("silent_disable", 32'(seen_id[2]), 0);

      // Sink toggling every 100 ns with all slots active.
      ready_mode = 3;
      for (int i = 0; i < 4; i++) cfg(i, int'($urandom % 2), int'($urandom_range(2, 9)), 1);
      run(200);

      // Fully random programming, sink and overflow clears.
      ready_mode = 2;
      rnd_cfg = 1'b1;
      run(1500);
      rnd_cfg = 1'b0;

      // Reset mid-stream with three words queued.
      ready_mode = 1;
      for (int i = 0; i < 4; i++) cfg(i, 0, 0, 0);
      run(10);
      ready_mode = 0;
      cfg(0, 0, 1, 1);
      run(4);
      chk("pre_reset_valid", 32'(da_Data_in_valid), 1);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(da_Data_in_valid), 0);
      chk("midrst_overflow", 32'(overflow), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      ready_mode = 1;
      clear_seen();
      run(20);
      chk("post_rst_silent", 32'(seen_id[0] + seen_id[1] + seen_id[2] + seen_id[3]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
